// File: rtl/game_btn_ctrl_if.sv
// Button controller bundle: mouse inputs, deal/dealer handshakes and the
// outputs that go to the button overlay and the game datapath.
//   master : the button controller (drives state, pulses, busy)
//   slave  : mouse + game logic side (drives mouse_*, deal_*, dealer_done)
interface game_btn_ctrl_if;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic        mouse_left;
  logic        deal_done;
  logic        player_bust;
  logic        dealer_done;
  logic [2:0]  state;
  logic        start_pulse;
  logic        hit_pulse;
  logic        stand_pulse;
  logic        busy;

  modport master (
    input  mouse_x, mouse_y, mouse_left, deal_done, player_bust, dealer_done,
    output state, start_pulse, hit_pulse, stand_pulse, busy
  );

  modport slave (
    output mouse_x, mouse_y, mouse_left, deal_done, player_bust, dealer_done,
    input  state, start_pulse, hit_pulse, stand_pulse, busy
  );
endinterface

// File: rtl/game_btn_ctrl.sv
// Blackjack button controller. Sequences the on-screen button set and turns
// mouse clicks (rising edges of the left button) that land on a visible
// button into one-cycle start/hit/stand pulses.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - game_btn_ctrl_if.master: mouse_x/y/left, deal_done, player_bust,
//          dealer_done in; state (overlay code), start/hit/stand pulses and
//          busy out.
module game_btn_ctrl #(
  parameter int unsigned BTN1_X        = 100,
  parameter int unsigned BTN1_Y        = 400,
  parameter int unsigned BTN2_X        = 300,
  parameter int unsigned BTN2_Y        = 400,
  parameter int unsigned BTN3_X        = 500,
  parameter int unsigned BTN3_Y        = 400,
  parameter int unsigned BTN_W         = 100,
  parameter int unsigned BTN_H         = 50,
  parameter int unsigned RESULT_CYCLES = 130000000
) (
  input logic             clk,
  input logic             rst,
  game_btn_ctrl_if.master bus
);

  localparam int unsigned CntW = $clog2(RESULT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(RESULT_CYCLES - 1);

  // Overlay codes; DEAL and HIT_WAIT share code 2.
  localparam logic [2:0] CodeIdle   = 3'd0;
  localparam logic [2:0] CodePlayer = 3'd1;
  localparam logic [2:0] CodeWait   = 3'd2;
  localparam logic [2:0] CodeDealer = 3'd3;
  localparam logic [2:0] CodeResult = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StDeal,
    StPlayer,
    StHitWait,
    StDealer,
    StResult
  } state_e;

  // Input stage: A registers the raw inputs, B holds the previous left level.
  logic [11:0] ax_q;
  logic [11:0] ay_q;
  logic        al_q;
  logic        bl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ax_q <= '0;
      ay_q <= '0;
      al_q <= 1'b0;
      bl_q <= 1'b0;
    end else begin
      ax_q <= bus.mouse_x;
      ay_q <= bus.mouse_y;
      al_q <= bus.mouse_left;
      bl_q <= al_q;
    end
  end

  function automatic logic inside_btn(input logic [11:0] x, input logic [11:0] y,
                                      input int unsigned bx, input int unsigned by);
    logic [12:0] xe;
    logic [12:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    return (xe >= 13'(bx)) && (xe < 13'(bx + BTN_W)) &&
           (ye >= 13'(by)) && (ye < 13'(by + BTN_H));
  endfunction

  logic click;
  logic in_start;
  logic in_hit;
  logic in_stand;

  always_comb begin
    click    = al_q & ~bl_q;
    in_start = inside_btn(ax_q, ay_q, BTN1_X, BTN1_Y);
    in_hit   = inside_btn(ax_q, ay_q, BTN2_X, BTN2_Y);
    in_stand = inside_btn(ax_q, ay_q, BTN3_X, BTN3_Y);
  end

  state_e          st_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      code_q;
  logic            start_q;
  logic            hit_q;
  logic            stand_q;
  logic            busy_q;

  // Single registered FSM; code_q/busy_q are updated together with st_q so
  // the overlay code and busy always agree with the state in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      code_q  <= CodeIdle;
      start_q <= 1'b0;
      hit_q   <= 1'b0;
      stand_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      hit_q   <= 1'b0;
      stand_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (click && in_start) begin
            start_q <= 1'b1;
            st_q    <= StDeal;
            code_q  <= CodeWait;
            busy_q  <= 1'b1;
          end
        end
        StDeal: begin
          if (bus.deal_done) begin
            st_q   <= StPlayer;
            code_q <= CodePlayer;
            busy_q <= 1'b0;
          end
        end
        StPlayer: begin
          if (click && in_hit) begin
            hit_q  <= 1'b1;
            st_q   <= StHitWait;
            code_q <= CodeWait;
            busy_q <= 1'b1;
          end else if (click && in_stand) begin
            stand_q <= 1'b1;
            st_q    <= StDealer;
            code_q  <= CodeDealer;
            busy_q  <= 1'b1;
          end
        end
        StHitWait: begin
          // Any click arriving here is dropped, including one coincident
          // with deal_done.
          if (bus.deal_done) begin
            if (bus.player_bust) begin
              st_q   <= StResult;
              code_q <= CodeResult;
              cnt_q  <= '0;
            end else begin
              st_q   <= StPlayer;
              code_q <= CodePlayer;
              busy_q <= 1'b0;
            end
          end
        end
        StDealer: begin
          if (bus.dealer_done) begin
            st_q   <= StResult;
            code_q <= CodeResult;
            cnt_q  <= '0;
          end
        end
        StResult: begin
          if (cnt_q == CntLast) begin
            st_q   <= StIdle;
            code_q <= CodeIdle;
            busy_q <= 1'b0;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          st_q   <= StIdle;
          code_q <= CodeIdle;
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.state       = code_q;
  assign bus.start_pulse = start_q;
  assign bus.hit_pulse   = hit_q;
  assign bus.stand_pulse = stand_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/game_btn_ctrl.md
Name: game_btn_ctrl

Overview:
- Blackjack button controller: sequences the on-screen button set and turns mouse clicks into one-cycle game action pulses.
- Drives the 3-bit `state` input of the button overlay (0 = START button shown, 1 = HIT/STAND shown, others = no buttons).
- Hit-tests registered mouse coordinates against the same button rectangles the overlay draws, and handshakes with the deal/dealer logic.
- Sits between the mouse interface and the card/game datapath, in the `clk` domain.

Parameters:
BTN1_X, 100, START button left edge (px)
BTN1_Y, 400, START button top edge (px)
BTN2_X, 300, HIT button left edge
BTN2_Y, 400, HIT button top edge
BTN3_X, 500, STAND button left edge
BTN3_Y, 400, STAND button top edge
BTN_W, 100, width of all buttons
BTN_H, 50, height of all buttons
RESULT_CYCLES, 130000000, RESULT display time in clk cycles (2 s at 65 MHz); counter width = $clog2(RESULT_CYCLES+1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
mouse_x  in  12  cursor x
mouse_y  in  12  cursor y
mouse_left  in  1  left button level
deal_done  in  1  1-cycle pulse: requested card(s) dealt to player
player_bust  in  1  player total > 21; valid in the cycle deal_done is high
dealer_done  in  1  1-cycle pulse: dealer play finished
state  out  3  FSM state code to the button overlay
start_pulse  out  1  1-cycle: new round requested
hit_pulse  out  1  1-cycle: player hits
stand_pulse  out  1  1-cycle: player stands
busy  out  1  high when state is 2, 3 or 4

Behaviour:
- Reset: asynchronous assert while rst=0. State goes to IDLE. All pulses, busy, input registers and the result counter go to 0. Release is synchronous to clk. Reset mid-round aborts immediately; no pulse is emitted.
- Input stage: mouse_x, mouse_y and mouse_left are registered once (stage A). A second register holds the previous left value (stage B).
- click = A_left & ~B_left. Only rising edges count; holding the button never repeats a click.
- inside(n): (A_x >= BTNn_X) & (A_x < BTNn_X+BTN_W) & (A_y >= BTNn_Y) & (A_y < BTNn_Y+BTN_H). Comparisons are 13-bit unsigned, so there is no overflow.
- Latency: mouse_left rises and is first sampled at edge E. The action pulse and the state change are both registered and appear at edge E+1; the pulse is high for exactly one cycle.
- States and codes:
  - IDLE=0: click & inside(1) -> start_pulse, go DEAL.
  - DEAL=2: deal_done -> PLAYER.
  - PLAYER=1: click & inside(2) -> hit_pulse, go HIT_WAIT. Else click & inside(3) -> stand_pulse, go DEALER.
  - HIT_WAIT=2: deal_done & player_bust -> RESULT. deal_done & ~player_bust -> PLAYER.
  - DEALER=3: dealer_done -> RESULT.
  - RESULT=4: counter loads 0 on entry and increments each cycle. When the count reaches RESULT_CYCLES-1 the FSM goes IDLE, so RESULT lasts exactly RESULT_CYCLES cycles.
- Ignored inputs:
  - Clicks in any state other than IDLE/PLAYER.
  - Clicks on a button not shown in the current state.
  - Clicks outside all rectangles.
  - deal_done/dealer_done in any state that does not await them.
- Simultaneous events:
  - Click together with deal_done in HIT_WAIT: the click is discarded.
  - Button held across PLAYER re-entry: no action until it is released and pressed again.
- Right/bottom edges are exclusive: x = BTNn_X+BTN_W is outside.
- At most one of start/hit/stand pulses is high in any cycle.
- busy is registered and consistent with state in the same cycle.

Test Plan:
- Reset, then mouse (150,420) and rising mouse_left -> start_pulse high one cycle at E+1; state 0->2; busy=1.
- In DEAL, pulse deal_done -> state=1. Click at (300,400) -> hit_pulse, state=2. deal_done with player_bust=0 -> state=1.
- In PLAYER, click at (599,449) -> stand_pulse, state=3. Then dealer_done -> state=4. With RESULT_CYCLES=10, state=0 exactly 10 cycles after entering 4.
- Boundary checks in PLAYER:
  - Click at (400,420) and (350,450): no pulse, state stays 1.
  - Click at (150,420) (START area): no pulse.
- Hold mouse_left high from IDLE through DEAL into PLAYER over HIT: no hit_pulse. Release then press -> hit_pulse.
- Assert rst=0 mid-HIT_WAIT, asynchronously between clock edges: state=0 and all outputs 0 before the next edge. A deal_done after release is ignored.
